ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_if.sv | 25 ++
 rtl/ex_stage.sv | 136 +++++++++++++
 tb/tb_ex_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Decode/execute/memory-side signal bundle of the execute stage.
interface ex_stage_if;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_forwarding;
  logic         stall_id_stop;
  logic         stallreq_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_forwarding, stall_id_stop, stallreq_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_forwarding, stall_id_stop, stallreq_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: input register, ALU, data-SRAM request and 33-cycle restoring divider with HI/LO.
// Outputs are combinational from the registered bus; stall[3] holds the stage, stallreq_ex freezes the pipe.
module ex_stage (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave ex
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [158:0] id_ex_q;
  logic [31:0]  pc, inst, rs_val, rt_val;
  logic [11:0]  alu_op;
  logic [2:0]   sel_alu_src1;
  logic [3:0]   sel_alu_src2, data_ram_wen;
  logic         data_ram_en, rf_we, sel_rf_res;
  logic [4:0]   rf_waddr;

  assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = id_ex_q;

  logic load;
  assign load = ~ex.stall[3];

  always_ff @(posedge clk) begin
    if (rst)       id_ex_q <= '0;
    else if (load) id_ex_q <= ex.stall[2] ? '0 : ex.id_to_ex_bus;
  end

  // ALU operand selection and one-hot result mux
  logic [31:0] src1, src2, alu_res, sra_res;
  assign src1 = ({32{sel_alu_src1[0]}} & rs_val)
              | ({32{sel_alu_src1[1]}} & pc)
              | ({32{sel_alu_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_alu_src2[0]}} & rt_val)
              | ({32{sel_alu_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_alu_src2[2]}} & 32'd8)
              | ({32{sel_alu_src2[3]}} & {16'b0, inst[15:0]});
  assign sra_res = $unsigned($signed(src2) >>> src1[4:0]);

  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  logic is_special, is_div, is_divu, is_divx, is_mfhi, is_mflo;
  assign is_special = (inst[31:26] == 6'd0);
  assign is_div     = is_special & (inst[5:0] == 6'h1A);
  assign is_divu    = is_special & (inst[5:0] == 6'h1B);
  assign is_divx    = is_div | is_divu;
  assign is_mfhi    = is_special & (inst[5:0] == 6'h10);
  assign is_mflo    = is_special & (inst[5:0] == 6'h12);

  div_state_t  state_q;
  logic        started_q, q_neg_q, r_neg_q, div0_q;
  logic [4:0]  cnt_q;
  logic [31:0] quot_q, rem_q, dsor_q, rs_raw_q, hi_q, lo_q;
  logic [32:0] rem_shift_d, diff_d;
  logic        ge_d;

  assign rem_shift_d = {rem_q, quot_q[31]};
  assign diff_d      = rem_shift_d - {1'b0, dsor_q};
  assign ge_d        = (rem_shift_d >= {1'b0, dsor_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dsor_q    <= '0;
      rs_raw_q  <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (is_divx && !started_q) begin
          started_q <= 1'b1;
          cnt_q     <= '0;
          rem_q     <= '0;
          quot_q    <= (is_div && rs_val[31]) ? -rs_val : rs_val;
          dsor_q    <= (is_div && rt_val[31]) ? -rt_val : rt_val;
          q_neg_q   <= is_div & (rs_val[31] ^ rt_val[31]);
          r_neg_q   <= is_div & rs_val[31];
          div0_q    <= (rt_val == 32'd0);
          rs_raw_q  <= rs_val;
          state_q   <= BUSY;
        end
        BUSY: begin
          quot_q <= {quot_q[30:0], ge_d};
          rem_q  <= ge_d ? diff_d[31:0] : rem_shift_d[31:0];
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DONE;
        end
        DONE: begin
          // Divide-by-zero reports raw dividend regardless of signedness
          lo_q    <= div0_q ? 32'hFFFF_FFFF : (q_neg_q ? -quot_q : quot_q);
          hi_q    <= div0_q ? rs_raw_q : (r_neg_q ? -rem_q : rem_q);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (load) started_q <= 1'b0;
    end
  end

  logic [31:0] ex_result;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  assign ex_result  = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign rf_we_o    = rf_we | is_mfhi | is_mflo;
  assign rf_waddr_o = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;

  assign ex.ex_to_mem_bus       = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we_o, rf_waddr_o, ex_result};
  assign ex.ex_to_id_forwarding = {rf_we_o, rf_waddr_o, ex_result};
  assign ex.stall_id_stop       = (inst[31:29] == 3'b100) & rf_we;
  assign ex.stallreq_ex         = (is_divx & ~started_q) | (state_q == BUSY);
  assign ex.data_sram_en        = data_ram_en;
  assign ex.data_sram_wen       = {4{data_ram_en}} & data_ram_wen;
  assign ex.data_sram_addr      = alu_res;
  assign ex.data_sram_wdata     = rt_val;

  logic unused_ok;
  assign unused_ok = ^{inst[25:16], ex.stall[5:4], ex.stall[1:0], diff_d[32]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, memory request, bubble/hold, divider timing and reset abort.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if ifc();
  ex_stage dut (.clk(clk), .rst(rst), .ex(ifc.slave));

  int vecs = 0;
  int errs = 0;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100;
  localparam logic [11:0] OP_NOR = 12'h040, OP_SRA = 12'h002, OP_LUI = 12'h001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                                      input logic en, input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sel, rs, rt};
  endfunction

  task automatic alu_vec(input string tag, input logic [31:0] inst, input logic [11:0] op,
                         input logic [2:0] s1, input logic [3:0] s2, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp);
    ifc.stall = '0;
    ifc.id_to_ex_bus = mk(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, rs, rt);
    step();
    chk(tag, {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd3, exp});
  endtask

  // mflo $8 and mfhi $9
  localparam logic [31:0] MFLO8 = 32'h0000_4012;
  localparam logic [31:0] MFHI9 = 32'h0000_4810;

  task automatic run_div(input string tag, input logic [31:0] inst, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    n = 0;
    ifc.stall = '0;
    ifc.id_to_ex_bus = mk(32'h400, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
    step();
    ifc.id_to_ex_bus = mk(32'h404, MFLO8, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    while (ifc.stallreq_ex === 1'b1 && n < 100) begin
      n++;
      ifc.stall = 6'b001111;
      step();
    end
    ifc.stall = '0;
    chk({tag, "_stall_cycles"}, 76'(n), 76'd33);
    step();
    chk({tag, "_mflo"}, {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd8, exp_lo});
    ifc.id_to_ex_bus = mk(32'h408, MFHI9, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    step();
    chk({tag, "_mfhi"}, {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd9, exp_hi});
  endtask

  logic [158:0] held_bus;
  logic [75:0]  held_exp;

  initial begin
    rst = 1'b1;
    ifc.stall = '0;
    ifc.id_to_ex_bus = '0;
    step();
    step();
    chk("rst_mem_bus", ifc.ex_to_mem_bus, 76'd0);
    chk("rst_fwd", {38'b0, ifc.ex_to_id_forwarding}, 76'd0);
    chk("rst_stallreq", {75'b0, ifc.stallreq_ex}, 76'd0);
    chk("rst_load_stop", {75'b0, ifc.stall_id_stop}, 76'd0);
    chk("rst_sram", {ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata}, 76'd0);
    rst = 1'b0;

    // addu $3, $1, $2 with wraparound
    ifc.id_to_ex_bus = mk(32'hBFC0_0000, 32'h0022_1821, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                          32'hFFFF_FFFF, 32'h1);
    step();
    chk("addu_mem_bus", ifc.ex_to_mem_bus, {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0});
    chk("addu_fwd", {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd3, 32'h0});

    // lw $4, -4($1)
    ifc.id_to_ex_bus = mk(32'hBFC0_0004, 32'h8C24_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1,
                          32'h1000, 32'h0);
    step();
    chk("lw_sram", {ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata},
        {1'b1, 4'h0, 32'h0000_0FFC, 32'h0});
    chk("lw_load_stop", {75'b0, ifc.stall_id_stop}, 76'd1);

    // sw $5, 8($1)
    ifc.id_to_ex_bus = mk(32'hBFC0_0008, 32'hAC25_0008, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                          32'h2000, 32'hDEAD_BEEF);
    step();
    chk("sw_sram", {ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata},
        {1'b1, 4'hF, 32'h0000_2008, 32'hDEAD_BEEF});
    chk("sw_load_stop", {75'b0, ifc.stall_id_stop}, 76'd0);

    alu_vec("sub",  32'h0022_1823, OP_SUB,  3'b001, 4'b0001, 32'h0, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("slt",  32'h0022_182A, OP_SLT,  3'b001, 4'b0001, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu", 32'h0022_182B, OP_SLTU, 3'b001, 4'b0001, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("nor",  32'h0022_1827, OP_NOR,  3'b001, 4'b0001, 32'h0, 32'h0, 32'hFF, 32'hFFFF_FF00);
    alu_vec("sra",  32'h0002_1903, OP_SRA,  3'b100, 4'b0001, 32'h0, 32'h0, 32'h8000_0000, 32'hF800_0000);
    alu_vec("lui",  32'h3C03_1234, OP_LUI,  3'b000, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h1234_0000);
    alu_vec("link", 32'h0C00_0000, OP_ADD,  3'b010, 4'b0100, 32'h100, 32'h0, 32'h0, 32'h108);
    alu_vec("none", 32'h0022_1821, 12'h0,   3'b001, 4'b0001, 32'h0, 32'd5, 32'd7, 32'h0);

    // Bubble when decode stops alone
    ifc.stall = 6'b000100;
    ifc.id_to_ex_bus = mk(32'h200, 32'h0022_1821, OP_ADD, 3'b001, 4'b0001, 1'b1, 4'hF, 1'b1, 5'd3, 1'b0,
                          32'd1, 32'd2);
    step();
    chk("bubble_mem_bus", ifc.ex_to_mem_bus, 76'd0);
    chk("bubble_sram", {ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata}, 76'd0);

    // Hold while execute stops
    ifc.stall = '0;
    held_bus = mk(32'h300, 32'h0022_1821, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                  32'd10, 32'd20);
    held_exp = {32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'd30};
    ifc.id_to_ex_bus = held_bus;
    step();
    chk("load_mem_bus", ifc.ex_to_mem_bus, held_exp);
    ifc.stall = 6'b001000;
    ifc.id_to_ex_bus = mk(32'h304, 32'h0022_1821, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
                          32'd1, 32'd1);
    step();
    step();
    chk("hold_mem_bus", ifc.ex_to_mem_bus, held_exp);
    ifc.stall = 6'b001100;
    step();
    chk("hold_both_mem_bus", ifc.ex_to_mem_bus, held_exp);

    // div $1, $2 : -7 / 2
    run_div("div_neg", 32'h0022_001A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    // divu 100 / 7
    run_div("divu", 32'h0022_001B, 32'd100, 32'd7, 32'd14, 32'd2);
    // divu by zero
    run_div("divu_zero", 32'h0022_001B, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);

    // Reset 10 cycles into BUSY aborts the divide
    ifc.stall = '0;
    ifc.id_to_ex_bus = mk(32'h500, 32'h0022_001B, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                          32'd1000, 32'd3);
    step();
    ifc.stall = 6'b001111;
    for (int i = 0; i < 11; i++) step();
    chk("busy_stallreq", {75'b0, ifc.stallreq_ex}, 76'd1);
    rst = 1'b1;
    step();
    chk("abort_stallreq", {75'b0, ifc.stallreq_ex}, 76'd0);
    chk("abort_mem_bus", ifc.ex_to_mem_bus, 76'd0);
    rst = 1'b0;
    ifc.stall = '0;
    ifc.id_to_ex_bus = mk(32'h504, MFLO8, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    step();
    chk("abort_lo", {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd8, 32'h0});
    ifc.id_to_ex_bus = mk(32'h508, MFHI9, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    step();
    chk("abort_hi", {38'b0, ifc.ex_to_id_forwarding}, {38'b0, 1'b1, 5'd9, 32'h0});
    step();
    chk("idle_stallreq", {75'b0, ifc.stallreq_ex}, 76'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
